// File: rtl/fp_align_prep_if.sv
// Format enum plus the handshake/data bundle between the adder front end and the alignment stage.
// The slave modport is the stage's view; master is the producer/consumer view.
package fp_align_prep_pkg;
    typedef enum logic {
        FMT_FP32 = 1'b0,
        FMT_FP16 = 1'b1
    } fp_fmt_e;
endpackage

interface fp_align_prep_if;
    import fp_align_prep_pkg::*;

    logic        in_valid;
    logic        in_ready;
    fp_fmt_e     fmt_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        sub_i;
    logic        out_valid;
    logic        out_ready;
    fp_fmt_e     fmt_o;
    logic [23:0] frac_small_o;
    logic [7:0]  shamt_o;
    logic [23:0] frac_big_o;
    logic [15:0] exp_big_o;
    logic [1:0]  sign_big_o;
    logic [1:0]  eff_sub_o;
    logic [1:0]  special_o;

    modport slave (
        input  in_valid, fmt_i, a_i, b_i, sub_i, out_ready,
        output in_ready, out_valid, fmt_o, frac_small_o, shamt_o, frac_big_o,
               exp_big_o, sign_big_o, eff_sub_o, special_o
    );

    modport master (
        output in_valid, fmt_i, a_i, b_i, sub_i, out_ready,
        input  in_ready, out_valid, fmt_o, frac_small_o, shamt_o, frac_big_o,
               exp_big_o, sign_big_o, eff_sub_o, special_o
    );
endinterface

// File: rtl/fp_align_prep.sv
// Unpacks/orders FP32 or FP16x2 operands for the shared barrel shifter; 2-cycle latency, 1 beat/cycle.
// Backpressure: each stage holds while full and blocked; in_ready = ~v1 | ~v2 | out_ready.
module fp_align_prep
    import fp_align_prep_pkg::*;
#(
    parameter int FP32_SAT = 31,
    parameter int FP16_SAT = 15
) (
    input  logic           clk,
    input  logic           rst,
    fp_align_prep_if.slave io
);

    localparam logic [7:0] SAT32 = 8'(FP32_SAT);
    localparam logic [7:0] SAT16 = 8'(FP16_SAT);

    function automatic logic [7:0] eff_exp(input logic [7:0] e);
        return (e == 8'd0) ? 8'd1 : e;
    endfunction

    function automatic logic [7:0] abs_diff(input logic [8:0] d);
        logic [8:0] m;
        m = d[8] ? (~d + 9'd1) : d;
        return m[7:0];
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic en1, en2, ld1, ld2;
    logic v1_q, v1_d, v2_q, v2_d;

    assign en2 = ~v2_q | io.out_ready;
    assign en1 = ~v1_q | en2;
    assign ld1 = en1 & io.in_valid;
    assign ld2 = en2 & v1_q;
    assign io.in_ready = en1;

    // The FP16 hi-lane exponent occupies the same bits as the FP32 exponent.
    logic [7:0] ea_hi, eb_hi, ea_lo, eb_lo;
    logic       sb_hi, sb_lo, spc_hi, spc_lo;

    assign ea_hi  = eff_exp(io.a_i[30:23]);
    assign eb_hi  = eff_exp(io.b_i[30:23]);
    assign ea_lo  = eff_exp(io.a_i[14:7]);
    assign eb_lo  = eff_exp(io.b_i[14:7]);
    assign sb_hi  = io.b_i[31] ^ io.sub_i;
    assign sb_lo  = io.b_i[15] ^ io.sub_i;
    assign spc_hi = (&io.a_i[30:23]) | (&io.b_i[30:23]);
    assign spc_lo = (&io.a_i[14:7]) | (&io.b_i[14:7]);

    fp_fmt_e     fmt1_q, fmt1_d;
    logic [15:0] exp_a1_q, exp_a1_d, exp_b1_q, exp_b1_d;
    logic [23:0] man_a1_q, man_a1_d, man_b1_q, man_b1_d;
    logic [1:0]  sgn_a1_q, sgn_a1_d, sgn_b1_q, sgn_b1_d;
    logic [1:0]  spc1_q, spc1_d;
    logic [8:0]  d_hi1_q, d_hi1_d, d_lo1_q, d_lo1_d;

    // Stage 1: FP32 uses the lo-lane slots for exponent, sign and difference.
    always_comb begin
        v1_d     = en1 ? io.in_valid : v1_q;
        fmt1_d   = fmt1_q;
        exp_a1_d = exp_a1_q;
        exp_b1_d = exp_b1_q;
        man_a1_d = man_a1_q;
        man_b1_d = man_b1_q;
        sgn_a1_d = sgn_a1_q;
        sgn_b1_d = sgn_b1_q;
        spc1_d   = spc1_q;
        d_hi1_d  = d_hi1_q;
        d_lo1_d  = d_lo1_q;
        if (ld1) begin
            fmt1_d = io.fmt_i;
            if (io.fmt_i == FMT_FP32) begin
                exp_a1_d = {8'd0, ea_hi};
                exp_b1_d = {8'd0, eb_hi};
                man_a1_d = {|io.a_i[30:23], io.a_i[22:0]};
                man_b1_d = {|io.b_i[30:23], io.b_i[22:0]};
                sgn_a1_d = {1'b0, io.a_i[31]};
                sgn_b1_d = {1'b0, sb_hi};
                spc1_d   = {1'b0, spc_hi};
                d_hi1_d  = 9'd0;
                d_lo1_d  = {1'b0, ea_hi} - {1'b0, eb_hi};
            end else begin
                exp_a1_d = {ea_hi, ea_lo};
                exp_b1_d = {eb_hi, eb_lo};
                man_a1_d = {|io.a_i[30:23], io.a_i[22:16], 8'd0, |io.a_i[14:7], io.a_i[6:0]};
                man_b1_d = {|io.b_i[30:23], io.b_i[22:16], 8'd0, |io.b_i[14:7], io.b_i[6:0]};
                sgn_a1_d = {io.a_i[31], io.a_i[15]};
                sgn_b1_d = {sb_hi, sb_lo};
                spc1_d   = {spc_hi, spc_lo};
                d_hi1_d  = {1'b0, ea_hi} - {1'b0, eb_hi};
                d_lo1_d  = {1'b0, ea_lo} - {1'b0, eb_lo};
            end
        end
    end

    // Exact ties keep A as the larger operand, so only a strictly larger B swaps.
    logic       sw32, sw_hi, sw_lo;
    logic [7:0] ad_hi, ad_lo, sh32, sh_hi, sh_lo;

    assign sw32  = d_lo1_q[8] | ((d_lo1_q == 9'd0) & (man_b1_q > man_a1_q));
    assign sw_hi = d_hi1_q[8] | ((d_hi1_q == 9'd0) & (man_b1_q[23:16] > man_a1_q[23:16]));
    assign sw_lo = d_lo1_q[8] | ((d_lo1_q == 9'd0) & (man_b1_q[7:0] > man_a1_q[7:0]));
    assign ad_hi = abs_diff(d_hi1_q);
    assign ad_lo = abs_diff(d_lo1_q);
    assign sh32  = clamp(ad_lo, SAT32);
    assign sh_hi = clamp(ad_hi, SAT16);
    assign sh_lo = clamp(ad_lo, SAT16);

    fp_fmt_e     fmt_o_q, fmt_o_d;
    logic [23:0] frac_small_q, frac_small_d, frac_big_q, frac_big_d;
    logic [7:0]  shamt_q, shamt_d;
    logic [15:0] exp_big_q, exp_big_d;
    logic [1:0]  sign_big_q, sign_big_d, eff_sub_q, eff_sub_d, special_q, special_d;

    always_comb begin
        v2_d         = en2 ? v1_q : v2_q;
        fmt_o_d      = fmt_o_q;
        frac_small_d = frac_small_q;
        frac_big_d   = frac_big_q;
        shamt_d      = shamt_q;
        exp_big_d    = exp_big_q;
        sign_big_d   = sign_big_q;
        eff_sub_d    = eff_sub_q;
        special_d    = special_q;
        if (ld2) begin
            fmt_o_d   = fmt1_q;
            special_d = spc1_q;
            eff_sub_d = sgn_a1_q ^ sgn_b1_q;
            if (fmt1_q == FMT_FP32) begin
                frac_big_d   = sw32 ? man_b1_q : man_a1_q;
                frac_small_d = sw32 ? man_a1_q : man_b1_q;
                exp_big_d    = {8'd0, sw32 ? exp_b1_q[7:0] : exp_a1_q[7:0]};
                sign_big_d   = {1'b0, sw32 ? sgn_b1_q[0] : sgn_a1_q[0]};
                shamt_d      = {3'b000, sh32[4:0]};
            end else begin
                frac_big_d   = {sw_hi ? man_b1_q[23:16] : man_a1_q[23:16], 8'd0,
                                sw_lo ? man_b1_q[7:0]   : man_a1_q[7:0]};
                frac_small_d = {sw_hi ? man_a1_q[23:16] : man_b1_q[23:16], 8'd0,
                                sw_lo ? man_a1_q[7:0]   : man_b1_q[7:0]};
                exp_big_d    = {sw_hi ? exp_b1_q[15:8] : exp_a1_q[15:8],
                                sw_lo ? exp_b1_q[7:0]  : exp_a1_q[7:0]};
                sign_big_d   = {sw_hi ? sgn_b1_q[1] : sgn_a1_q[1],
                                sw_lo ? sgn_b1_q[0] : sgn_a1_q[0]};
                shamt_d      = {sh_hi[3:0], sh_lo[3:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            fmt1_q       <= FMT_FP32;
            exp_a1_q     <= '0;
            exp_b1_q     <= '0;
            man_a1_q     <= '0;
            man_b1_q     <= '0;
            sgn_a1_q     <= '0;
            sgn_b1_q     <= '0;
            spc1_q       <= '0;
            d_hi1_q      <= '0;
            d_lo1_q      <= '0;
            fmt_o_q      <= FMT_FP32;
            frac_small_q <= '0;
            frac_big_q   <= '0;
            shamt_q      <= '0;
            exp_big_q    <= '0;
            sign_big_q   <= '0;
            eff_sub_q    <= '0;
            special_q    <= '0;
        end else begin
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            fmt1_q       <= fmt1_d;
            exp_a1_q     <= exp_a1_d;
            exp_b1_q     <= exp_b1_d;
            man_a1_q     <= man_a1_d;
            man_b1_q     <= man_b1_d;
            sgn_a1_q     <= sgn_a1_d;
            sgn_b1_q     <= sgn_b1_d;
            spc1_q       <= spc1_d;
            d_hi1_q      <= d_hi1_d;
            d_lo1_q      <= d_lo1_d;
            fmt_o_q      <= fmt_o_d;
            frac_small_q <= frac_small_d;
            frac_big_q   <= frac_big_d;
            shamt_q      <= shamt_d;
            exp_big_q    <= exp_big_d;
            sign_big_q   <= sign_big_d;
            eff_sub_q    <= eff_sub_d;
            special_q    <= special_d;
        end
    end

    assign io.out_valid    = v2_q;
    assign io.fmt_o        = fmt_o_q;
    assign io.frac_small_o = frac_small_q;
    assign io.frac_big_o   = frac_big_q;
    assign io.shamt_o      = shamt_q;
    assign io.exp_big_o    = exp_big_q;
    assign io.sign_big_o   = sign_big_q;
    assign io.eff_sub_o    = eff_sub_q;
    assign io.special_o    = special_q;

endmodule

// File: tb/tb_fp_align_prep.sv
// Directed-vector bench for fp_align_prep: value checks per format, boundaries, backpressure and reset.
module tb_fp_align_prep;
    import fp_align_prep_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    fp_align_prep_if bus ();

    fp_align_prep #(.FP32_SAT(31), .FP16_SAT(15)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    // {out_valid, fmt, shamt, frac_big, frac_small, exp_big, sign_big, eff_sub, special}
    function automatic logic [79:0] obs();
        return {bus.out_valid, bus.fmt_o, bus.shamt_o, bus.frac_big_o, bus.frac_small_o,
                bus.exp_big_o, bus.sign_big_o, bus.eff_sub_o, bus.special_o};
    endfunction

    function automatic logic [79:0] expv(input fp_fmt_e f, input logic [7:0] sh,
                                         input logic [23:0] fb, input logic [23:0] fs,
                                         input logic [15:0] eb, input logic [1:0] sb,
                                         input logic [1:0] es, input logic [1:0] sp);
        return {1'b1, f, sh, fb, fs, eb, sb, es, sp};
    endfunction

    task automatic send(input fp_fmt_e f, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        bus.fmt_i     = f;
        bus.a_i       = a;
        bus.b_i       = b;
        bus.sub_i     = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== 80'h0) begin
            fails++;
            $display("FAIL reset_outputs got %h exp %h", obs(), 80'h0);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_fp32_align();
        logic [31:0] va [0:8];
        logic [31:0] vb [0:8];
        logic        vs [0:8];
        logic [79:0] ve [0:8];
        va = '{32'h3F800000, 32'h2B800000, 32'h4F000000, 32'h4E800000, 32'h00000001,
               32'h00800000, 32'h40400000, 32'h40400000, 32'h3E000000};
        vb = '{32'h3E000000, 32'hBF800000, 32'h3F800000, 32'h3F800000, 32'h00000002,
               32'h00400000, 32'h40400000, 32'hC0400000, 32'h3F800000};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ve = '{expv(FMT_FP32, 8'h03, 24'h800000, 24'h800000, 16'h007F, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP32, 8'h1F, 24'h800000, 24'h800000, 16'h007F, 2'b01, 2'b01, 2'b00),
               expv(FMT_FP32, 8'h1F, 24'h800000, 24'h800000, 16'h009E, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP32, 8'h1E, 24'h800000, 24'h800000, 16'h009D, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP32, 8'h00, 24'h000002, 24'h000001, 16'h0001, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP32, 8'h00, 24'h800000, 24'h400000, 16'h0001, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP32, 8'h00, 24'hC00000, 24'hC00000, 16'h0080, 2'b00, 2'b01, 2'b00),
               expv(FMT_FP32, 8'h00, 24'hC00000, 24'hC00000, 16'h0080, 2'b00, 2'b01, 2'b00),
               expv(FMT_FP32, 8'h03, 24'h800000, 24'h800000, 16'h007F, 2'b01, 2'b01, 2'b00)};
        for (int i = 0; i < 9; i++) begin
            send(FMT_FP32, va[i], vb[i], vs[i]);
            checks++;
            if (obs() !== ve[i]) begin
                fails++;
                $display("FAIL fp32_vec%0d got %h exp %h", i, obs(), ve[i]);
            end
        end
    endtask

    task automatic test_fp16_lanes();
        logic [31:0] va [0:4];
        logic [31:0] vb [0:4];
        logic        vs [0:4];
        logic [79:0] ve [0:4];
        va = '{32'h3F804100, 32'h47804680, 32'h47003F80, 32'h3FC03F80, 32'hBF803F80};
        vb = '{32'h40003F80, 32'h3F803F80, 32'h3F804700, 32'h3F803FC0, 32'h3F803F80};
        vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ve = '{expv(FMT_FP16, 8'h13, 24'h800080, 24'h800080, 16'h8082, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP16, 8'hFE, 24'h800080, 24'h800080, 16'h8F8D, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP16, 8'hFF, 24'h800080, 24'h800080, 16'h8E8E, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP16, 8'h00, 24'hC000C0, 24'h800080, 16'h7F7F, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP16, 8'h00, 24'h800080, 24'h800080, 16'h7F7F, 2'b10, 2'b01, 2'b00)};
        for (int i = 0; i < 5; i++) begin
            send(FMT_FP16, va[i], vb[i], vs[i]);
            checks++;
            if (obs() !== ve[i]) begin
                fails++;
                $display("FAIL fp16_vec%0d got %h exp %h", i, obs(), ve[i]);
            end
        end
    endtask

    task automatic test_special();
        fp_fmt_e     vf [0:2];
        logic [31:0] va [0:2];
        logic [31:0] vb [0:2];
        logic [79:0] ve [0:2];
        vf = '{FMT_FP32, FMT_FP16, FMT_FP16};
        va = '{32'h7F800000, 32'h7F803F80, 32'h3F803F80};
        vb = '{32'h3F800000, 32'h3F803F80, 32'h3F807FC0};
        ve = '{expv(FMT_FP32, 8'h1F, 24'h800000, 24'h800000, 16'h00FF, 2'b00, 2'b00, 2'b01),
               expv(FMT_FP16, 8'hF0, 24'h800080, 24'h800080, 16'hFF7F, 2'b00, 2'b00, 2'b10),
               expv(FMT_FP16, 8'h0F, 24'h8000C0, 24'h800080, 16'h7FFF, 2'b00, 2'b00, 2'b01)};
        for (int i = 0; i < 3; i++) begin
            send(vf[i], va[i], vb[i], 1'b0);
            checks++;
            if (obs() !== ve[i]) begin
                fails++;
                $display("FAIL special_vec%0d got %h exp %h", i, obs(), ve[i]);
            end
        end
    endtask

    // Alternating formats streamed on consecutive cycles: one output per cycle after 2 cycles.
    task automatic test_fmt_switch();
        fp_fmt_e     vf [0:2];
        logic [31:0] va [0:2];
        logic [31:0] vb [0:2];
        logic [79:0] ve [0:2];
        vf = '{FMT_FP16, FMT_FP32, FMT_FP16};
        va = '{32'h3F804100, 32'h3F800000, 32'h47804680};
        vb = '{32'h40003F80, 32'h3E000000, 32'h3F803F80};
        ve = '{expv(FMT_FP16, 8'h13, 24'h800080, 24'h800080, 16'h8082, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP32, 8'h03, 24'h800000, 24'h800000, 16'h007F, 2'b00, 2'b00, 2'b00),
               expv(FMT_FP16, 8'hFE, 24'h800080, 24'h800080, 16'h8F8D, 2'b00, 2'b00, 2'b00)};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (obs() !== ve[c-2]) begin
                    fails++;
                    $display("FAIL fmt_switch_beat%0d got %h exp %h", c - 2, obs(), ve[c-2]);
                end
            end
            bus.in_valid = (c < 3);
            if (c < 3) begin
                bus.fmt_i = vf[c];
                bus.a_i   = va[c];
                bus.b_i   = vb[c];
                bus.sub_i = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          in_idx  = 0;
        int          out_idx = 0;
        logic [79:0] ev [0:3];
        for (int k = 0; k < 4; k++)
            ev[k] = expv(FMT_FP32, 8'(k + 1), 24'h800000, 24'h800000,
                         16'(8'h7F + 8'(k + 1)), 2'b00, 2'b00, 2'b00);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 4);
            bus.in_valid  = (in_idx < 4);
            bus.fmt_i     = FMT_FP32;
            bus.a_i       = {1'b0, 8'(8'h7F + 8'(in_idx + 1)), 23'd0};
            bus.b_i       = 32'h3F800000;
            bus.sub_i     = 1'b0;
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (bus.in_ready !== 1'b0 || in_idx != 2) begin
                    fails++;
                    $display("FAIL bp_stall_cyc%0d in_ready %b accepted %0d, exp 0 and 2",
                             cyc, bus.in_ready, in_idx);
                end
                checks++;
                if (obs() !== ev[0]) begin
                    fails++;
                    $display("FAIL bp_hold_cyc%0d got %h exp %h", cyc, obs(), ev[0]);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (out_idx >= 4) begin
                    fails++;
                    $display("FAIL bp_extra_beat got %h exp none", obs());
                end else if (obs() !== ev[out_idx]) begin
                    fails++;
                    $display("FAIL bp_order_beat%0d got %h exp %h", out_idx, obs(), ev[out_idx]);
                end
                out_idx++;
            end
            if (bus.in_valid && bus.in_ready) in_idx++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (out_idx != 4) begin
            fails++;
            $display("FAIL bp_count got %0d exp 4", out_idx);
        end
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        bus.fmt_i     = FMT_FP32;
        bus.sub_i     = 1'b0;
        bus.b_i       = 32'h3F800000;
        @(negedge clk);
        bus.a_i      = 32'h40000000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.a_i = 32'h40400000;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midflight_full out_valid %b in_ready %b exp 1 0", bus.out_valid, bus.in_ready);
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 80'h0) begin
            fails++;
            $display("FAIL midflight_flush got %h exp %h", obs(), 80'h0);
        end
        rst           = 1'b0;
        bus.a_i       = 32'h40800000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midflight_early got out_valid %b exp 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (obs() !== expv(FMT_FP32, 8'h02, 24'h800000, 24'h800000, 16'h0081, 2'b00, 2'b00, 2'b00)) begin
            fails++;
            $display("FAIL midflight_first_beat got %h exp %h", obs(),
                     expv(FMT_FP32, 8'h02, 24'h800000, 24'h800000, 16'h0081, 2'b00, 2'b00, 2'b00));
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midflight_replay got out_valid %b exp 0", bus.out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.fmt_i     = FMT_FP32;
        bus.a_i       = '0;
        bus.b_i       = '0;
        bus.sub_i     = 1'b0;
        test_reset();
        test_fp32_align();
        test_fp16_lanes();
        test_special();
        test_fmt_switch();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
